// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low patterns (bit0 = seg a .. bit6 = seg g)
// and the receiver state encoding. The display decoder reuses the same constants.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Indexed by nibble value
  localparam logic [6:0] SEG_TABLE [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  typedef enum logic [1:0] {
    GET_FIRST,
    GET_SECOND,
    HOLD
  } seg_rx_state_t;

endpackage

// File: rtl/seg_pattern_to_nibble.sv
// Combinational inverse of the hex display decoder: active-low pattern -> {legal, nibble}.
module seg_pattern_to_nibble
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_to_hex_receiver.sv
// Seven-segment link receiver: pairs decoded digits into a byte on a valid/ready handshake.
// Optional saturating error counter port err_count when SEG_ERR_COUNT_EN is defined.
module seg_to_hex_receiver
  import seg_pkg::*;
#(
  parameter int LOW_FIRST = 1,
  parameter int TIMEOUT   = 0
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic       seg_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       err
`ifdef SEG_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  seg_rx_state_t state_q, state_d;
  logic [3:0]    nib_q, nib_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    byte_d;
  logic          valid_d;
  logic          err_d;
  logic          legal;
  logic [3:0]    nibble;
  logic          accept;

  seg_pattern_to_nibble u_dec (
    .seg    (seg_in),
    .legal  (legal),
    .nibble (nibble)
  );

  assign seg_ready = (state_q != HOLD);
  assign accept    = seg_valid && seg_ready;

  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    timer_d = timer_q;
    byte_d  = byte_out;
    valid_d = byte_valid;
    err_d   = 1'b0;
    case (state_q)
      GET_FIRST: begin
        if (accept) begin
          if (legal) begin
            nib_d   = nibble;
            timer_d = '0;
            state_d = GET_SECOND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GET_SECOND: begin
        if (accept) begin
          if (legal) begin
            byte_d  = (LOW_FIRST != 0) ? {nibble, nib_q} : {nib_q, nibble};
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            err_d   = 1'b1;
            state_d = GET_FIRST;
          end
        end else if (TIMEOUT > 0) begin
          // Firing on timer == TIMEOUT-1 lets an accept on the TIMEOUT-th idle edge win
          if (timer_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            timer_d = '0;
            state_d = GET_FIRST;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (byte_ready) begin
          valid_d = 1'b0;
          state_d = GET_FIRST;
        end
      end
      default: state_d = GET_FIRST;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= GET_FIRST;
      nib_q      <= '0;
      timer_q    <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      timer_q    <= timer_d;
      byte_out   <= byte_d;
      byte_valid <= valid_d;
      err        <= err_d;
    end
  end

`ifdef SEG_ERR_COUNT_EN
  always_ff @(posedge clock) begin
    if (clear) begin
      err_count <= '0;
    end else if (err_d && (err_count != '1)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
